regfile_sb: RTL
===============

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, number of registers; power of two, >= 2.
REQ-003 SHALL have parameter BYPASS, default 1: 1 forwards same-cycle write data to reads, 0 does not.
REQ-004 SHALL derive localparam AW = clog2(DEPTH) as the address width.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have ports addr_a and addr_b, input, AW bits each: read port A and B addresses.
REQ-008 SHALL have ports data_a and data_b, output, WIDTH bits each: combinational read data.
REQ-009 SHALL have ports wr_en (input, 1), addr_d (input, AW) and data_in (input, WIDTH): writeback port.
REQ-010 SHALL have ports rsv_en (input, 1) and rsv_addr (input, AW): destination reservation at issue.
REQ-011 SHALL have ports busy_a and busy_b, output, 1 bit each: the addressed register has a pending write.
REQ-012 SHALL have port stall, output, 1 bit: busy_a OR busy_b.
REQ-013 SHALL have port pend_cnt, output, AW+1 bits: number of registers currently reserved.

Function
REQ-014 SHALL hold register 0 at zero permanently; writes and reservations to address 0 are ignored.
REQ-015 SHALL write data_in to register addr_d on the rising edge when wr_en=1 and addr_d!=0.
REQ-016 SHALL make reads combinational; data_a = reg[addr_a] and data_b = reg[addr_b].
REQ-017 SHALL, when BYPASS=1, wr_en=1, addr_d!=0 and addr_x==addr_d, drive data_x=data_in in that cycle.
REQ-018 SHALL, when BYPASS=0, show the new value only from the cycle after the write edge.
REQ-019 SHALL keep one busy bit per register; busy[0] is constant 0.
REQ-020 SHALL set busy[rsv_addr] on the edge when rsv_en=1 and rsv_addr!=0.
REQ-021 SHALL clear busy[addr_d] on the edge when wr_en=1 and addr_d!=0.
REQ-022 SHALL give set priority when a reservation and a writeback target the same register on the same edge; busy stays 1.
REQ-023 SHALL count a reservation of an already-busy register once only; repeat reservations are idempotent.
REQ-024 SHALL still perform a writeback to a non-busy register and leave its busy bit 0.
REQ-025 SHALL drive busy_x = busy[addr_x]; when BYPASS=1, a same-cycle writeback to addr_x clears busy_x unless a same-cycle reservation also targets addr_x.
REQ-026 SHALL keep pend_cnt equal to the popcount of the busy vector after each edge; maximum value DEPTH-1, no wrap.
REQ-027 SHALL produce all outputs without latches and with no combinational path from rsv_* to data_*.

Reset
REQ-028 SHALL, on a rising edge with rst=1, clear every register, every busy bit and pend_cnt to 0.
REQ-029 SHALL give rst priority over wr_en and rsv_en on the same edge.
REQ-030 SHALL drive data_a, data_b, busy_a, busy_b and stall to 0 in the cycle after reset, for any address (BYPASS=0 or wr_en=0).
REQ-031 SHALL discard all pending reservations when reset is asserted mid-operation; later writebacks to those registers behave per REQ-024.

Structure
REQ-032 SHALL place the shared constants in package regfile_pkg: default WIDTH and DEPTH, and the clog2-based AW helper.
REQ-033 SHALL implement the busy vector, the REQ-025 forwarding and pend_cnt in sub-module regfile_scoreboard; regfile_sb holds the storage array and data forwarding.

Verification
REQ-034 SHALL check: rst=1, then read addr_a=3, addr_b=7 -> data_a=0, data_b=0, pend_cnt=0, stall=0.
REQ-035 SHALL check: write 0xA5 to r2, then read addr_a=2 -> 0xA5 one cycle later; with BYPASS=1 and addr_a=2, data_a=0xA5 in the write cycle.
REQ-036 SHALL check: wr_en=1, addr_d=0, data_in=0xFF, and rsv_en=1, rsv_addr=0 -> data_a(addr_a=0)=0, busy_a=0, pend_cnt unchanged.
REQ-037 SHALL check: reserve r5, then r5 again -> pend_cnt=1 and stall=1 with addr_a=5; writeback r5=0x3C -> busy cleared, pend_cnt=0, data_a=0x3C.
REQ-038 SHALL check: same-edge reserve r4 and writeback r4=0x11 -> busy[4]=1, reg[4]=0x11, pend_cnt incremented by 1.
REQ-039 SHALL check: reserve r1, r2, r3, then rst=1 on the same edge as wr_en for r6 -> all busy bits 0, pend_cnt=0, reg[6]=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants for the scoreboarded register file: default geometry and
// the address-width helper used by the top and the scoreboard.
package regfile_pkg;

   localparam int DEFAULT_WIDTH = 8;
   localparam int DEFAULT_DEPTH = 8;

   // Address width for a register count; a one-bit address is the floor.
   function automatic int aw_f(input int depth);
      return (depth < 2) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one pending-write flag per register, read-port busy
// forwarding and a registered count of reserved registers.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int DEPTH  = DEFAULT_DEPTH,
   parameter int BYPASS = 1,
   parameter int AW     = aw_f(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] addr_a,
   input  logic [AW-1:0] addr_b,
   input  logic          wr_en,
   input  logic [AW-1:0] addr_d,
   input  logic          rsv_en,
   input  logic [AW-1:0] rsv_addr,
   output logic          busy_a,
   output logic          busy_b,
   output logic          stall,
   output logic [AW:0]   pend_cnt
);

   logic [DEPTH-1:0] busy_q, busy_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic             wr_hit, rsv_hit;

   assign wr_hit  = wr_en  && (addr_d   != '0);
   assign rsv_hit = rsv_en && (rsv_addr != '0);

   // Clear on writeback first so a same-edge reservation wins.
   always_comb begin
      busy_d = busy_q;
      if (wr_hit) begin
         busy_d[addr_d] = 1'b0;
      end
      if (rsv_hit) begin
         busy_d[rsv_addr] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_comb begin
      cnt_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
         cnt_d = cnt_d + {{AW{1'b0}}, busy_d[i]};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= '0;
         cnt_q  <= '0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
      end
   end

   // A retiring write hides the busy flag unless it is re-reserved this cycle.
   always_comb begin
      busy_a = busy_q[addr_a];
      busy_b = busy_q[addr_b];
      if (BYPASS != 0 && wr_hit) begin
         if (addr_a == addr_d && !(rsv_hit && rsv_addr == addr_a)) begin
            busy_a = 1'b0;
         end
         if (addr_b == addr_d && !(rsv_hit && rsv_addr == addr_b)) begin
            busy_b = 1'b0;
         end
      end
   end

   assign stall    = busy_a | busy_b;
   assign pend_cnt = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Two-read, one-write register file with hardwired-zero r0, optional
// write-to-read forwarding and a reservation scoreboard for pending writes.
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int WIDTH  = DEFAULT_WIDTH,
   parameter int DEPTH  = DEFAULT_DEPTH,
   parameter int BYPASS = 1,
   localparam int AW    = aw_f(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [AW-1:0]    addr_a,
   input  logic [AW-1:0]    addr_b,
   output logic [WIDTH-1:0] data_a,
   output logic [WIDTH-1:0] data_b,
   input  logic             wr_en,
   input  logic [AW-1:0]    addr_d,
   input  logic [WIDTH-1:0] data_in,
   input  logic             rsv_en,
   input  logic [AW-1:0]    rsv_addr,
   output logic             busy_a,
   output logic             busy_b,
   output logic             stall,
   output logic [AW:0]      pend_cnt
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             wr_hit;

   assign wr_hit = wr_en && (addr_d != '0);

   // Entry 0 is only ever loaded by reset, so it reads as zero forever.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (wr_hit) begin
         mem_q[addr_d] <= data_in;
      end
   end

   always_comb begin
      data_a = mem_q[addr_a];
      data_b = mem_q[addr_b];
      if (BYPASS != 0 && wr_hit) begin
         if (addr_a == addr_d) begin
            data_a = data_in;
         end
         if (addr_b == addr_d) begin
            data_b = data_in;
         end
      end
   end

   regfile_scoreboard #(
      .DEPTH  (DEPTH),
      .BYPASS (BYPASS),
      .AW     (AW)
   ) u_scoreboard (
      .clk      (clk),
      .rst      (rst),
      .addr_a   (addr_a),
      .addr_b   (addr_b),
      .wr_en    (wr_en),
      .addr_d   (addr_d),
      .rsv_en   (rsv_en),
      .rsv_addr (rsv_addr),
      .busy_a   (busy_a),
      .busy_b   (busy_b),
      .stall    (stall),
      .pend_cnt (pend_cnt)
   );

endmodule
